// File: rtl/gray_onehot_pkg.sv
// rtl/gray_onehot_pkg.sv - shared widths, result type and decode helpers for the Gray/one-hot decoder
package gray_onehot_pkg;

  localparam int CODE_W = 7;
  localparam int BIN_W  = 3;

  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic             code_err;
  } dec_result_t;

  function automatic logic [BIN_W-1:0] gray2bin(input logic [BIN_W-1:0] g);
    gray2bin = {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
  endfunction

  // Only meaningful for a word with at most one bit set; bit k maps to k+1.
  function automatic logic [BIN_W-1:0] onehot2bin(input logic [CODE_W-1:0] c);
    logic [BIN_W-1:0] r;
    r = '0;
    for (int k = 0; k < CODE_W; k++) begin
      if (c[k]) r = BIN_W'(k + 1);
    end
    onehot2bin = r;
  endfunction

  function automatic logic [1:0] popcount3(input logic [BIN_W-1:0] x);
    popcount3 = {1'b0, x[0]} + {1'b0, x[1]} + {1'b0, x[2]};
  endfunction

endpackage

// File: rtl/gray_onehot_decode_comb.sv
// rtl/gray_onehot_decode_comb.sv - combinational code word to binary decode with malformed-word flag
module gray_onehot_decode_comb
  import gray_onehot_pkg::*;
#(
  parameter bit USE_GRAY = 1'b1
) (
  input  logic [CODE_W-1:0] code_in,
  output logic [BIN_W-1:0]  bin,
  output logic              code_err
);

  generate
    if (USE_GRAY) begin : g_gray
      always_comb begin
        bin      = '0;
        code_err = 1'b0;
        if (code_in[CODE_W-1:BIN_W] != '0) begin
          code_err = 1'b1;
        end else begin
          bin = gray2bin(code_in[BIN_W-1:0]);
        end
      end
    end else begin : g_onehot
      // x & (x-1) clears the lowest set bit; anything left means two or more bits set.
      always_comb begin
        bin      = '0;
        code_err = 1'b0;
        if ((code_in & (code_in - CODE_W'(1))) != '0) begin
          code_err = 1'b1;
        end else begin
          bin = onehot2bin(code_in);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/gray_onehot_decoder_pipe.sv
// rtl/gray_onehot_decoder_pipe.sv - registered Gray/one-hot decoder with handshake, step check and error counter
module gray_onehot_decoder_pipe
  import gray_onehot_pkg::*;
#(
  parameter bit USE_GRAY   = 1'b1,
  parameter bit CHECK_STEP = 1'b1,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] code_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BIN_W-1:0]  bin_out,
  output logic              code_err,
  output logic              step_err,
  output logic [CNT_W-1:0]  err_count
);

  logic              r_out_valid;
  logic [BIN_W-1:0]  r_bin;
  logic              r_code_err;
  logic              r_step_err;
  logic [CNT_W-1:0]  r_err_count;
  logic [BIN_W-1:0]  r_prev_code;
  logic              r_has_prev;

  logic              w_accept;
  logic [BIN_W-1:0]  w_bin;
  logic              w_code_err;
  logic              w_step_err;
  logic              w_any_err;
  logic              w_track_prev;

  gray_onehot_decode_comb #(
    .USE_GRAY (USE_GRAY)
  ) u_decode (
    .code_in  (code_in),
    .bin      (w_bin),
    .code_err (w_code_err)
  );

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Only well-formed Gray words take part in step tracking.
  assign w_track_prev = USE_GRAY && !w_code_err;
  assign w_step_err   = USE_GRAY && CHECK_STEP && !w_code_err && r_has_prev &&
                        (popcount3(code_in[BIN_W-1:0] ^ r_prev_code) > 2'd1);
  assign w_any_err    = w_code_err || w_step_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_bin       <= '0;
      r_code_err  <= 1'b0;
      r_step_err  <= 1'b0;
      r_err_count <= '0;
      r_prev_code <= '0;
      r_has_prev  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_bin       <= w_bin;
      r_code_err  <= w_code_err;
      r_step_err  <= w_step_err;
      if (w_any_err && (r_err_count != '1)) begin
        r_err_count <= r_err_count + CNT_W'(1);
      end
      // Resynchronise on every good word, even one that raised a step error.
      if (w_track_prev) begin
        r_prev_code <= code_in[BIN_W-1:0];
        r_has_prev  <= 1'b1;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign bin_out   = r_bin;
  assign code_err  = r_code_err;
  assign step_err  = r_step_err;
  assign err_count = r_err_count;

endmodule
